// File: rtl/fifo_prog_sync_pkg.sv
// Shared definitions for the programmable-threshold synchronous FIFO.
// Default geometry, derived pointer width, word/count types and the count-update opcode.
package fifo_prog_sync_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  // Pointer width for a given depth; depth is always >= 2, so $clog2 is never zero.
  function automatic int addr_w_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int ADDR_W = addr_w_f(FIFO_DEPTH);

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
  typedef logic [ADDR_W:0]       fifo_cnt_t;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/fifo_prog_sync_if.sv
// Handshake/status bundle between a producer/consumer (master) and fifo_prog_sync (slave).
interface fifo_prog_sync_if #(
  parameter int FIFO_WIDTH = fifo_prog_sync_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = fifo_prog_sync_pkg::FIFO_DEPTH
);
  localparam int ADDR_W = fifo_prog_sync_pkg::addr_w_f(FIFO_DEPTH);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  flush;
  logic [ADDR_W:0]       af_thresh;
  logic [ADDR_W:0]       ae_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [ADDR_W:0]       level;

  modport master (
    output wr_en, data_in, rd_en, flush, af_thresh, ae_thresh,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, level
  );

  modport slave (
    input  wr_en, data_in, rd_en, flush, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, level
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Circular FIFO pointer: increments on enable, wraps at FIFO_DEPTH-1 by explicit compare,
// synchronous clear, asynchronous active-low reset.
module fifo_wrap_ptr #(
  parameter int FIFO_DEPTH = fifo_prog_sync_pkg::FIFO_DEPTH,
  parameter int ADDR_W     = fifo_prog_sync_pkg::addr_w_f(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FIFO_DEPTH - 1);

  // Non-power-of-two depths rely on this compare; natural overflow would visit unused slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_prog_sync.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, any depth >= 2, and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module fifo_prog_sync
  import fifo_prog_sync_pkg::*;
#(
  parameter int FIFO_WIDTH = fifo_prog_sync_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = fifo_prog_sync_pkg::FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_prog_sync_if.slave bus
);

  localparam int ADDR_W = addr_w_f(FIFO_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       count;
  logic                  full;
  logic                  empty;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_step;
  logic                  rd_step;
  cnt_op_e               cnt_op;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A read frees a slot in the same cycle, so a full FIFO still takes a simultaneous write.
  assign rd_acc  = bus.rd_en && !empty;
  assign wr_acc  = bus.wr_en && (!full || rd_acc);
  assign wr_step = wr_acc && !bus.flush;
  assign rd_step = rd_acc && !bus.flush;

  fifo_wrap_ptr #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_step),
    .clr   (bus.flush),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_step),
    .clr   (bus.flush),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_step) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_comb begin
    cnt_op = CNT_HOLD;
    if (wr_acc && !rd_acc) begin
      cnt_op = CNT_INC;
    end else if (rd_acc && !wr_acc) begin
      cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      case (cnt_op)
        CNT_INC: count <= count + 1'b1;
        CNT_DEC: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- stage p1: request-cycle status, visible one cycle later ----
  logic wr_ack_p1;
  logic overflow_p1;
  logic underflow_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_p1    <= 1'b0;
      overflow_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
    end else if (bus.flush) begin
      wr_ack_p1    <= 1'b0;
      overflow_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
    end else begin
      wr_ack_p1    <= wr_acc;
      overflow_p1  <= bus.wr_en && !wr_acc;
      underflow_p1 <= bus.rd_en && !rd_acc;
    end
  end

  assign bus.wr_ack    = wr_ack_p1;
  assign bus.overflow  = overflow_p1;
  assign bus.underflow = underflow_p1;

`ifdef FIFO_FWFT_EN
  // Head word is always on display; rd_en simply pops it.
  assign bus.data_out = mem[rd_ptr];
  assign bus.rd_valid = !empty;
`else
  // ---- stage p1: registered read data ----
  logic [FIFO_WIDTH-1:0] data_p1;
  logic                  vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (bus.flush) begin
      vld_p1  <= 1'b0;
    end else if (rd_acc) begin
      data_p1 <= mem[rd_ptr];
      vld_p1  <= 1'b1;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.data_out = data_p1;
  assign bus.rd_valid = vld_p1;
`endif

  // Thresholds are used live, so software can retune them without a flush.
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count >= bus.af_thresh);
  assign bus.almostempty = (count <= bus.ae_thresh);
  assign bus.level       = count;

endmodule
